// File: rtl/uart_pkg.sv
// Shared types and legal-range constants for the extended UART receiver.
// The PARITY state exists only when UART_RX_PARITY_EN is defined.
`timescale 1ns/1ps
package uart_pkg;

  localparam int unsigned DATA_BITS_MIN  = 5;
  localparam int unsigned DATA_BITS_MAX  = 9;
  localparam int unsigned STOP_BITS_MIN  = 1;
  localparam int unsigned STOP_BITS_MAX  = 2;
  localparam int unsigned OVERSAMPLE_LO  = 8;
  localparam int unsigned OVERSAMPLE_HI  = 16;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
`ifdef UART_RX_PARITY_EN
    ST_PARITY    = 3'd3,
`endif
    ST_STOP      = 3'd4,
    ST_WAIT_HIGH = 3'd5
  } uart_state_e;

  // 2-of-3 vote used for every bit decision
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_ext_if.sv
// Receiver-side signal bundle: serial line in, word/flag handshake out.
`timescale 1ns/1ps
interface uart_rx_ext_if #(
  parameter int unsigned DATA_BITS = 8
) ();
  logic                 rx;
  logic                 rx_ready;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 frame_err;
  logic                 parity_err;
  logic                 overrun;
  logic                 busy;

  modport master (
    input  rx, rx_ready,
    output rx_data, rx_valid, frame_err, parity_err, overrun, busy
  );

  modport slave (
    output rx, rx_ready,
    input  rx_data, rx_valid, frame_err, parity_err, overrun, busy
  );
endinterface

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: one-cycle tick every DIV clocks, realigned by restart.
`timescale 1ns/1ps
module uart_baud_tick #(
  parameter int unsigned DIV = 78
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  output logic tick
);
  localparam int unsigned CW = $clog2(DIV) + 1;

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (restart) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (cnt == CW'(DIV - 1)) begin
      cnt  <= '0;
      tick <= 1'b1;
    end else begin
      cnt  <= cnt + 1'b1;
      tick <= 1'b0;
    end
  end
endmodule

// File: rtl/uart_rx_ext.sv
// Oversampling UART receiver with majority voting, break handling and a valid/ready output.
// Optional parity check enabled by defining UART_RX_PARITY_EN.
`timescale 1ns/1ps
module uart_rx_ext
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = 12000000,
  parameter int unsigned BAUD_RATE   = 9600,
  parameter int unsigned DATA_BITS   = 8,
  parameter int unsigned STOP_BITS   = 1,
  parameter int unsigned OVERSAMPLE  = 16,
  parameter int unsigned PARITY_ODD  = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun,
  output logic                 busy
);
  localparam int unsigned DIV = CLK_FREQ_HZ / (BAUD_RATE * OVERSAMPLE);
  localparam int unsigned SW  = $clog2(OVERSAMPLE);
  localparam int unsigned MID = OVERSAMPLE / 2;
  localparam int unsigned BW  = 4;

  if (DATA_BITS < DATA_BITS_MIN || DATA_BITS > DATA_BITS_MAX ||
      STOP_BITS < STOP_BITS_MIN || STOP_BITS > STOP_BITS_MAX ||
      (OVERSAMPLE != OVERSAMPLE_LO && OVERSAMPLE != OVERSAMPLE_HI) ||
      PARITY_ODD > 1 || DIV < 1) begin : g_bad_cfg
    $error("uart_rx_ext: illegal parameter set");
  end

  logic                 rx_m, rx_s;
  uart_state_e          state, state_nxt;
  logic                 tick, restart_c;
  logic [SW-1:0]        samp_cnt;
  logic [BW-1:0]        bit_cnt;
  logic                 s0, s1;
  logic [DATA_BITS-1:0] shreg;
  logic                 ferr_acc;
  logic                 decide_c, bit_val_c, last_c, done_c;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
    end
  end

  // Divider phase is realigned to the detected start edge
  assign restart_c = (state == ST_IDLE) && !rx_s;

  uart_baud_tick #(.DIV(DIV)) u_tick (
    .clk     (clk),
    .rst_n   (rst_n),
    .restart (restart_c),
    .tick    (tick)
  );

  assign decide_c  = tick && (samp_cnt == SW'(MID + 1));
  assign bit_val_c = maj3(s0, s1, rx_s);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Every transition out of a bit-timed state happens on that bit's vote
  always_comb begin
    state_nxt = state;
    last_c    = 1'b0;
    done_c    = 1'b0;
    case (state)
      ST_IDLE:      if (!rx_s) state_nxt = ST_START;
      ST_START:     if (decide_c) begin
                      last_c    = 1'b1;
                      state_nxt = bit_val_c ? ST_IDLE : ST_DATA;
                    end
      ST_DATA:      if (decide_c && bit_cnt == BW'(DATA_BITS - 1)) begin
                      last_c    = 1'b1;
`ifdef UART_RX_PARITY_EN
                      state_nxt = ST_PARITY;
`else
                      state_nxt = ST_STOP;
`endif
                    end
`ifdef UART_RX_PARITY_EN
      ST_PARITY:    if (decide_c) begin
                      last_c    = 1'b1;
                      state_nxt = ST_STOP;
                    end
`endif
      ST_STOP:      if (decide_c && bit_cnt == BW'(STOP_BITS - 1)) begin
                      last_c    = 1'b1;
                      done_c    = 1'b1;
                      state_nxt = bit_val_c ? ST_IDLE : ST_WAIT_HIGH;
                    end
      ST_WAIT_HIGH: if (rx_s) state_nxt = ST_IDLE;
      default:      state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      samp_cnt <= '0;
      bit_cnt  <= '0;
      s0       <= 1'b0;
      s1       <= 1'b0;
      shreg    <= '0;
      ferr_acc <= 1'b0;
    end else if (state == ST_IDLE || state == ST_WAIT_HIGH) begin
      samp_cnt <= '0;
      bit_cnt  <= '0;
      ferr_acc <= 1'b0;
    end else begin
      if (tick) begin
        samp_cnt <= samp_cnt + 1'b1;
        if (samp_cnt == SW'(MID - 1)) s0 <= rx_s;
        if (samp_cnt == SW'(MID))     s1 <= rx_s;
      end
      if (decide_c) begin
        bit_cnt <= last_c ? '0 : bit_cnt + 1'b1;
        if (state == ST_DATA) shreg <= {bit_val_c, shreg[DATA_BITS-1:1]};
        if (state == ST_STOP && !bit_val_c) ferr_acc <= 1'b1;
      end
    end
  end

`ifdef UART_RX_PARITY_EN
  logic par_acc, par_bad;

  always_ff @(posedge clk) begin
    if (!rst_n || state == ST_IDLE) begin
      par_acc <= 1'b0;
      par_bad <= 1'b0;
    end else if (decide_c && state == ST_DATA) begin
      par_acc <= par_acc ^ bit_val_c;
    end else if (decide_c && state == ST_PARITY) begin
      par_bad <= (par_acc ^ bit_val_c) != 1'(PARITY_ODD);
    end
  end
`else
  assign parity_err = 1'b0;
`endif

  // Held word is never overwritten while the consumer still owes a handshake
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      frame_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err <= 1'b0;
`endif
      overrun    <= 1'b0;
      busy       <= 1'b0;
    end else begin
      overrun <= 1'b0;
      busy    <= (state_nxt != ST_IDLE);
      if (done_c && rx_valid && !rx_ready) begin
        overrun <= 1'b1;
      end else if (done_c) begin
        rx_data    <= shreg;
        rx_valid   <= 1'b1;
        frame_err  <= ferr_acc | !bit_val_c;
`ifdef UART_RX_PARITY_EN
        parity_err <= par_bad;
`endif
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end
endmodule

// File: doc/uart_rx_ext.md
UART_RX_EXT -- requirements
Module: uart_rx_ext

Interface
REQ-001 SHALL have parameter CLK_FREQ_HZ, default 12000000: system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 9600: line bit rate.
REQ-003 SHALL have parameter DATA_BITS, default 8: data bits per frame, legal 5..9.
REQ-004 SHALL have parameter STOP_BITS, default 1: stop bits checked, legal 1..2.
REQ-005 SHALL have parameter OVERSAMPLE, default 16: sample ticks per bit, legal 8 or 16.
REQ-006 SHALL have parameter PARITY_ODD, default 0: 0 selects even parity, 1 selects odd; used only with UART_RX_PARITY_EN.
REQ-007 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-008 SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-009 SHALL have port rx, input, 1 bit: asynchronous serial line, idle high.
REQ-010 SHALL have port rx_data, output, DATA_BITS: received word, LSB first on the line.
REQ-011 SHALL have port rx_valid, output, 1 bit: rx_data and error flags are valid.
REQ-012 SHALL have port rx_ready, input, 1 bit: consumer accepts the word.
REQ-013 SHALL have port frame_err, output, 1 bit: at least one stop bit of the held word sampled low.
REQ-014 SHALL have port parity_err, output, 1 bit: parity mismatch on the held word.
REQ-015 SHALL have port overrun, output, 1 bit: one-cycle pulse when a completed frame is dropped.
REQ-016 SHALL have port busy, output, 1 bit: high in every state except IDLE.

Function
REQ-017 SHALL pass rx through a 2-flop synchronizer; all decisions use the synchronized value.
REQ-018 SHALL generate a sample tick every DIV = CLK_FREQ_HZ/(BAUD_RATE*OVERSAMPLE) clocks, truncated; the tick counter is width $clog2(DIV)+1 and is restarted on start-edge detection.
REQ-019 SHALL implement states IDLE, START, DATA, PARITY, STOP and WAIT_HIGH.
REQ-020 IDLE: synchronized rx low -> START.
REQ-021 Each bit value SHALL be the 2-of-3 majority of samples at ticks OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1 of that bit.
REQ-022 START: majority high -> IDLE (false start, no output); majority low -> DATA.
REQ-023 DATA: shift DATA_BITS bits in LSB first, then -> PARITY if UART_RX_PARITY_EN is defined, else -> STOP.
REQ-024 STOP: check STOP_BITS bits; after the decision on the last stop bit -> IDLE if it was high, -> WAIT_HIGH if it was low.
REQ-025 WAIT_HIGH: stay until synchronized rx is high, then -> IDLE; this prevents a break condition from being read as repeated frames.
REQ-026 At the last stop-bit decision, rx_data, frame_err, parity_err and rx_valid SHALL update on the next clock edge.
REQ-027 Handshake: rx_valid SHALL stay high until a cycle with rx_valid && rx_ready, then clear on the next edge unless a new word loads in that same edge.
REQ-028 Completion while rx_valid is high and rx_ready is low: the new frame is discarded, held data and flags are unchanged, and overrun pulses for 1 cycle.
REQ-029 Completion in the same cycle as an accepting handshake: the new word loads, rx_valid stays high, and overrun stays 0.
REQ-030 A frame with errors SHALL still be delivered, with its flags set.

Reset
REQ-031 While rst_n is low at a clk edge: state is IDLE; rx_data, rx_valid, frame_err, parity_err, overrun and busy are 0; all counters are 0; synchronizer flops are 1.
REQ-032 Reset mid-frame SHALL abandon the frame with no output; the next start edge after release is received normally.

Configuration
REQ-033 SHALL use macro UART_RX_PARITY_EN: when defined, the PARITY state checks one parity bit against PARITY_ODD.
REQ-034 Without UART_RX_PARITY_EN: there is no PARITY state, no parity bit is expected, and parity_err is tied to 0.

Structure
REQ-035 Package uart_pkg SHALL hold the state enum typedef and the legal-range constants for DATA_BITS, STOP_BITS and OVERSAMPLE.
REQ-036 The sample-tick divider SHALL be sub-module uart_baud_tick, with inputs clk, rst_n and restart and output tick.

Verification (CLK_FREQ_HZ=12000000, BAUD_RATE=9600, OVERSAMPLE=16, DIV=78)
REQ-037 8N1 frame of 0x55 with rx_ready=1 -> rx_valid for 1 cycle, rx_data=0x55, frame_err=0, parity_err=0.
REQ-038 rx low pulse of 20 us from idle -> START rejects it, busy returns to 0, rx_valid never rises.
REQ-039 Frame 0xA3 with stop bit low, then line held low 2 ms -> rx_data=0xA3 with frame_err=1; block stays in WAIT_HIGH and produces no further words until rx rises.
REQ-040 Frames 0x11 then 0x22 back-to-back, rx_ready=0 -> overrun pulses once and rx_data stays 0x11; raising rx_ready clears rx_valid.
REQ-041 With UART_RX_PARITY_EN and PARITY_ODD=0: 0x07 sent with parity bit 0 -> parity_err=1; sent with parity bit 1 -> parity_err=0.
REQ-042 rst_n low for 1 cycle during bit 4 of a frame -> busy=0 and no rx_valid; next frame 0x3C is received correctly.
